// File: rtl/mem_pkg.sv
// Shared definitions for the block memory models: FSM states, default sizes
// and the byte-offset width helper.
package mem_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } mem_state_e;

    localparam int MEM_BLOCK_BITS = 128;
    localparam int MEM_LATENCY    = 20;

    // Number of low address bits that select a byte inside one block.
    function automatic int offset_bits(input int block_bits);
        return $clog2(block_bits / 8);
    endfunction

endpackage

// File: rtl/mem_latency_counter.sv
// Down-counter that times one memory access: load with L, done_o is high in the
// cycle whose closing edge brings the count to zero.
module mem_latency_counter #(
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic             busy_o,
    output logic             done_o
);

    logic [CNT_W-1:0] count_q, count_d;
    logic             active_q, active_d;

    always_comb begin
        count_d  = count_q;
        active_d = active_q;
        if (load_i) begin
            count_d  = load_val_i;
            active_d = 1'b1;
        end else if (active_q) begin
            count_d = count_q - CNT_W'(1);
            if (count_q == CNT_W'(1)) begin
                active_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q  <= '0;
            active_q <= 1'b0;
        end else begin
            count_q  <= count_d;
            active_q <= active_d;
        end
    end

    assign busy_o = active_q;
    assign done_o = active_q && (count_q == CNT_W'(1));

endmodule

// File: rtl/block_memory_model.sv
// Multi-cycle block backing store with a valid/ready request and a one-cycle
// response pulse. Optional open-row latency model: define MEM_OPEN_ROW_EN.
module block_memory_model
    import mem_pkg::*;
#(
    parameter int BLOCK_BITS      = MEM_BLOCK_BITS,
    parameter int ADDR_BITS       = 32,
    parameter int DEPTH_LOG2      = 16,
    parameter int LATENCY         = MEM_LATENCY,
    parameter int ROW_BLOCKS_LOG2 = 4,
    parameter int ROW_HIT_LATENCY = 6
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_read,
    input  logic                  req_write,
    input  logic [ADDR_BITS-1:0]  read_address,
    input  logic [ADDR_BITS-1:0]  write_address,
    input  logic [BLOCK_BITS-1:0] write_data,
    output logic                  resp_valid,
    output logic [BLOCK_BITS-1:0] read_data
);

    localparam int OFFSET = offset_bits(BLOCK_BITS);
    localparam int DEPTH  = 1 << DEPTH_LOG2;
    localparam int CNT_W  = $clog2(LATENCY + 1);

    if (BLOCK_BITS < 32 || LATENCY < 1 || ROW_HIT_LATENCY < 1 ||
        ROW_HIT_LATENCY > LATENCY || ROW_BLOCKS_LOG2 < 0 ||
        ADDR_BITS < OFFSET + DEPTH_LOG2) begin : g_bad_cfg
        $error("block_memory_model: illegal parameter combination");
    end

    logic [BLOCK_BITS-1:0] mem_q [DEPTH];

    mem_state_e            state_q, state_d;
    logic                  resp_valid_q;
    logic [BLOCK_BITS-1:0] read_data_q, read_data_d;
    logic                  rd_q, wr_q;
    logic [DEPTH_LOG2-1:0] ridx_q, widx_q;
    logic [BLOCK_BITS-1:0] wdata_q;

    logic [DEPTH_LOG2-1:0] ridx_in, widx_in;
    logic                  accept, done, cnt_busy;
    logic [CNT_W-1:0]      lat_sel;
    logic                  unused_addr_bits;

    assign ridx_in = read_address[OFFSET +: DEPTH_LOG2];
    assign widx_in = write_address[OFFSET +: DEPTH_LOG2];
    assign unused_addr_bits = ^{read_address, write_address, cnt_busy};
    assign accept  = req_valid && (state_q == IDLE);

`ifdef MEM_OPEN_ROW_EN
    localparam int ROW_SPAN = DEPTH_LOG2 - ROW_BLOCKS_LOG2;
    localparam int ROW_W    = (ROW_SPAN > 0) ? ROW_SPAN : 1;

    logic [ROW_W-1:0] open_row_q, trow_q, rrow_in, wrow_in;
    logic             open_valid_q, row_hit;

    assign rrow_in = ROW_W'(ridx_in >> ROW_BLOCKS_LOG2);
    assign wrow_in = ROW_W'(widx_in >> ROW_BLOCKS_LOG2);
    // A no-op never counts as a hit, so it always pays the full latency.
    assign row_hit = open_valid_q && (req_read || req_write) &&
                     (!req_read  || rrow_in == open_row_q) &&
                     (!req_write || wrow_in == open_row_q);
    assign lat_sel = row_hit ? CNT_W'(ROW_HIT_LATENCY) : CNT_W'(LATENCY);

    always_ff @(posedge clk) begin
        if (accept) begin
            trow_q <= req_read ? rrow_in : wrow_in;
        end
        if (reset) begin
            open_valid_q <= 1'b0;
            open_row_q   <= '0;
        end else if (done && (rd_q || wr_q)) begin
            open_valid_q <= 1'b1;
            open_row_q   <= trow_q;
        end
    end
`else
    assign lat_sel = CNT_W'(LATENCY);
`endif

    mem_latency_counter #(
        .CNT_W (CNT_W)
    ) u_lat (
        .clk        (clk),
        .reset      (reset),
        .load_i     (accept),
        .load_val_i (lat_sel),
        .busy_o     (cnt_busy),
        .done_o     (done)
    );

    always_comb begin
        state_d     = state_q;
        read_data_d = read_data_q;
        case (state_q)
            IDLE: if (accept) state_d = BUSY;
            BUSY: if (done)   state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // The read of a combined transaction observes its own evicted block.
        if (done && rd_q) begin
            read_data_d = (wr_q && (widx_q == ridx_q)) ? wdata_q : mem_q[ridx_q];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            resp_valid_q <= 1'b0;
            read_data_q  <= '0;
        end else begin
            state_q      <= state_d;
            resp_valid_q <= done;
            read_data_q  <= read_data_d;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            rd_q    <= req_read;
            wr_q    <= req_write;
            ridx_q  <= ridx_in;
            widx_q  <= widx_in;
            wdata_q <= write_data;
        end
        if (!reset && done && wr_q) begin
            mem_q[widx_q] <= wdata_q;
        end
    end

    assign req_ready  = (state_q == IDLE);
    assign resp_valid = resp_valid_q;
    assign read_data  = read_data_q;

endmodule

// File: tb/tb_block_memory_model.sv
// Directed self-checking bench for block_memory_model (DEPTH_LOG2=4 so aliasing
// is reachable); expectations adapt when MEM_OPEN_ROW_EN is defined.
module tb_block_memory_model;

    localparam int BB  = 128;
    localparam int AB  = 32;
    localparam int LAT = 20;
    localparam int HIT = 6;
`ifdef MEM_OPEN_ROW_EN
    localparam bit ROW_EN = 1'b1;
`else
    localparam bit ROW_EN = 1'b0;
`endif

    localparam logic [BB-1:0] PAT_A = 128'h0123456789ABCDEF0123456789ABCDEF;
    localparam logic [BB-1:0] PAT_B = 128'h11112222333344445555666677778888;
    localparam logic [BB-1:0] PAT_AA = {16{8'hAA}};
    localparam logic [BB-1:0] PAT_C = 128'hC0FFEE00C0FFEE01C0FFEE02C0FFEE03;
    localparam logic [BB-1:0] PAT_D = 128'hDEADBEEFDEADBEEFDEADBEEFDEADBEEF;
    localparam logic [BB-1:0] PAT_E = 128'h5A5A5A5AA5A5A5A55A5A5A5AA5A5A5A5;
    localparam logic [BB-1:0] PAT_F = 128'hFFFF0000FFFF0000FFFF0000FFFF0000;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_read = 1'b0;
    logic          req_write = 1'b0;
    logic [AB-1:0] read_address = '0;
    logic [AB-1:0] write_address = '0;
    logic [BB-1:0] write_data = '0;
    logic          resp_valid;
    logic [BB-1:0] read_data;

    int total = 0;
    int bad = 0;

    int m_open_row = 0;
    bit m_open_valid = 1'b0;

    always #5 clk = ~clk;

    block_memory_model #(
        .BLOCK_BITS      (BB),
        .ADDR_BITS       (AB),
        .DEPTH_LOG2      (4),
        .LATENCY         (LAT),
        .ROW_BLOCKS_LOG2 (2),
        .ROW_HIT_LATENCY (HIT)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_read      (req_read),
        .req_write     (req_write),
        .read_address  (read_address),
        .write_address (write_address),
        .write_data    (write_data),
        .resp_valid    (resp_valid),
        .read_data     (read_data)
    );

    // Row = (address bits [7:4]) >> 2 for 16-byte blocks, 16 blocks, 4 blocks per row.
    function automatic int row_of(input logic [AB-1:0] a);
        return int'((a >> 4) & 32'hF) >> 2;
    endfunction

    function automatic int model_lat(input bit rd, input bit wr,
                                     input logic [AB-1:0] ra, input logic [AB-1:0] wa);
        bit hit;
        hit = m_open_valid && (rd || wr) &&
              (!rd || row_of(ra) == m_open_row) && (!wr || row_of(wa) == m_open_row);
        return (ROW_EN && hit) ? HIT : LAT;
    endfunction

    task automatic model_done(input bit rd, input bit wr,
                              input logic [AB-1:0] ra, input logic [AB-1:0] wa);
        if (rd || wr) begin
            m_open_row   = rd ? row_of(ra) : row_of(wa);
            m_open_valid = 1'b1;
        end
    endtask

    // Issue one request from idle and wait (bounded) for its response pulse.
    task automatic run_txn(input bit rd, input bit wr, input logic [AB-1:0] ra,
                           input logic [AB-1:0] wa, input logic [BB-1:0] wd,
                           output int lat, output int exp_lat,
                           output logic [BB-1:0] rdata, output logic ready);
        exp_lat = model_lat(rd, wr, ra, wa);
        @(negedge clk);
        req_valid = 1'b1; req_read = rd; req_write = wr;
        read_address = ra; write_address = wa; write_data = wd;
        @(posedge clk);
        #1;
        req_valid = 1'b0; req_read = 1'b0; req_write = 1'b0;
        lat = -1;
        for (int j = 0; j < 60; j++) begin
            @(negedge clk);
            if (resp_valid === 1'b1) begin
                lat = j;
                break;
            end
        end
        rdata = read_data;
        ready = req_ready;
        if (lat >= 0) model_done(rd, wr, ra, wa);
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        m_open_valid = 1'b0;
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", req_ready); end
        total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL reset_resp got=%b want=0", resp_valid); end
        total++; if (read_data !== '0) begin bad++; $display("FAIL reset_rdata got=%h want=0", read_data); end
    endtask

    task automatic test_write_read;
        int lat, exp_lat;
        logic [BB-1:0] rd;
        logic rdy;
        run_txn(1'b0, 1'b1, '0, 32'h40, PAT_A, lat, exp_lat, rd, rdy);
        total++; if (lat !== exp_lat) begin bad++; $display("FAIL wr_latency got=%0d want=%0d", lat, exp_lat); end
        total++; if (rd !== '0) begin bad++; $display("FAIL wr_only_holds got=%h want=0", rd); end
        total++; if (rdy !== 1'b1) begin bad++; $display("FAIL wr_ready_on_resp got=%b want=1", rdy); end
        @(negedge clk);
        total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL resp_pulse_width got=%b want=0", resp_valid); end
        run_txn(1'b1, 1'b0, 32'h40, '0, '0, lat, exp_lat, rd, rdy);
        total++; if (lat !== exp_lat) begin bad++; $display("FAIL rd_latency got=%0d want=%0d", lat, exp_lat); end
        total++; if (rd !== PAT_A) begin bad++; $display("FAIL rd_data got=%h want=%h", rd, PAT_A); end
    endtask

    task automatic test_evict_load;
        int lat, exp_lat;
        logic [BB-1:0] rd;
        logic rdy;
        run_txn(1'b0, 1'b1, '0, 32'h90, PAT_B, lat, exp_lat, rd, rdy);
        run_txn(1'b1, 1'b1, 32'h80, 32'h80, PAT_AA, lat, exp_lat, rd, rdy);
        total++; if (lat !== exp_lat) begin bad++; $display("FAIL evload_latency got=%0d want=%0d", lat, exp_lat); end
        total++; if (rd !== PAT_AA) begin bad++; $display("FAIL evload_data got=%h want=%h", rd, PAT_AA); end
        run_txn(1'b1, 1'b0, 32'h90, '0, '0, lat, exp_lat, rd, rdy);
        total++; if (rd !== PAT_B) begin bad++; $display("FAIL other_block got=%h want=%h", rd, PAT_B); end
        run_txn(1'b1, 1'b0, 32'h80, '0, '0, lat, exp_lat, rd, rdy);
        total++; if (rd !== PAT_AA) begin bad++; $display("FAIL evict_stored got=%h want=%h", rd, PAT_AA); end
    endtask

    task automatic test_back_to_back;
        int lat1, lat2, exp1, exp2, busy_err;
        exp1 = model_lat(1'b1, 1'b0, 32'h40, '0);
        @(negedge clk);
        req_valid = 1'b1; req_read = 1'b1; req_write = 1'b0; read_address = 32'h40;
        @(posedge clk);
        #1;
        busy_err = 0;
        lat1 = -1;
        for (int j = 0; j < 60; j++) begin
            @(negedge clk);
            if (resp_valid === 1'b1) begin
                lat1 = j;
                break;
            end
            if (req_ready !== 1'b0) busy_err++;
            read_address  = 32'h80 + 32'(j * 16);
            write_address = 32'h40;
            write_data    = PAT_F;
            req_write     = j[0];
        end
        total++; if (busy_err !== 0) begin bad++; $display("FAIL busy_ready_low got=%0d want=0", busy_err); end
        total++; if (lat1 !== exp1) begin bad++; $display("FAIL b2b_first_latency got=%0d want=%0d", lat1, exp1); end
        total++; if (read_data !== PAT_A) begin bad++; $display("FAIL b2b_first_data got=%h want=%h", read_data, PAT_A); end
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready_on_resp got=%b want=1", req_ready); end
        if (lat1 >= 0) model_done(1'b1, 1'b0, 32'h40, '0);
        read_address = 32'h80; req_write = 1'b0;
        exp2 = model_lat(1'b1, 1'b0, 32'h80, '0);
        @(posedge clk);
        #1;
        req_valid = 1'b0; req_read = 1'b0;
        lat2 = -1;
        for (int j = 0; j < 60; j++) begin
            @(negedge clk);
            if (j == 0) begin
                total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL b2b_second_accept got=%b want=0", req_ready); end
            end
            if (resp_valid === 1'b1) begin
                lat2 = j;
                break;
            end
        end
        total++; if (lat2 !== exp2) begin bad++; $display("FAIL b2b_second_latency got=%0d want=%0d", lat2, exp2); end
        total++; if (read_data !== PAT_AA) begin bad++; $display("FAIL b2b_second_data got=%h want=%h", read_data, PAT_AA); end
        if (lat2 >= 0) model_done(1'b1, 1'b0, 32'h80, '0);
    endtask

    task automatic test_reset_abort;
        int lat, exp_lat, seen;
        logic [BB-1:0] rd;
        logic rdy;
        run_txn(1'b0, 1'b1, '0, 32'h100, PAT_C, lat, exp_lat, rd, rdy);
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; write_address = 32'h100; write_data = PAT_D;
        @(posedge clk);
        #1;
        req_valid = 1'b0; req_write = 1'b0;
        seen = 0;
        repeat (5) begin
            @(negedge clk);
            if (resp_valid === 1'b1) seen++;
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        m_open_valid = 1'b0;
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL abort_ready got=%b want=1", req_ready); end
        total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL abort_resp got=%b want=0", resp_valid); end
        total++; if (read_data !== '0) begin bad++; $display("FAIL abort_rdata got=%h want=0", read_data); end
        repeat (30) begin
            @(negedge clk);
            if (resp_valid === 1'b1) seen++;
        end
        total++; if (seen !== 0) begin bad++; $display("FAIL abort_no_resp got=%0d want=0", seen); end
        run_txn(1'b1, 1'b0, 32'h100, '0, '0, lat, exp_lat, rd, rdy);
        total++; if (rd !== PAT_C) begin bad++; $display("FAIL abort_no_commit got=%h want=%h", rd, PAT_C); end
    endtask

    task automatic test_alias_noop;
        int lat, exp_lat;
        logic [BB-1:0] rd;
        logic rdy;
        run_txn(1'b0, 1'b1, '0, 32'h10, PAT_E, lat, exp_lat, rd, rdy);
        run_txn(1'b1, 1'b0, 32'h110, '0, '0, lat, exp_lat, rd, rdy);
        total++; if (rd !== PAT_E) begin bad++; $display("FAIL alias_data got=%h want=%h", rd, PAT_E); end
        run_txn(1'b0, 1'b0, 32'h40, 32'h40, PAT_F, lat, exp_lat, rd, rdy);
        total++; if (lat !== LAT) begin bad++; $display("FAIL noop_latency got=%0d want=%0d", lat, LAT); end
        total++; if (rd !== PAT_E) begin bad++; $display("FAIL noop_holds got=%h want=%h", rd, PAT_E); end
        run_txn(1'b1, 1'b0, 32'h40, '0, '0, lat, exp_lat, rd, rdy);
        total++; if (rd !== PAT_A) begin bad++; $display("FAIL noop_no_write got=%h want=%h", rd, PAT_A); end
    endtask

    task automatic test_open_row;
        int lat, exp_lat;
        logic [BB-1:0] rd;
        logic rdy;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        m_open_valid = 1'b0;
        run_txn(1'b1, 1'b0, 32'h0, '0, '0, lat, exp_lat, rd, rdy);
        total++; if (lat !== LAT) begin bad++; $display("FAIL row_first_miss got=%0d want=%0d", lat, LAT); end
        total++; if (rd !== PAT_C) begin bad++; $display("FAIL row_first_data got=%h want=%h", rd, PAT_C); end
        run_txn(1'b1, 1'b0, 32'h10, '0, '0, lat, exp_lat, rd, rdy);
        total++; if (lat !== (ROW_EN ? HIT : LAT)) begin bad++; $display("FAIL row_hit got=%0d want=%0d", lat, ROW_EN ? HIT : LAT); end
        total++; if (rd !== PAT_E) begin bad++; $display("FAIL row_hit_data got=%h want=%h", rd, PAT_E); end
        run_txn(1'b1, 1'b0, 32'h40, '0, '0, lat, exp_lat, rd, rdy);
        total++; if (lat !== LAT) begin bad++; $display("FAIL row_second_miss got=%0d want=%0d", lat, LAT); end
        total++; if (rd !== PAT_A) begin bad++; $display("FAIL row_second_data got=%h want=%h", rd, PAT_A); end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_evict_load();
        test_back_to_back();
        test_reset_abort();
        test_alias_noop();
        test_open_row();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
